// File: rtl/tank_pkg.sv
// tank_pkg: shared constants and region encodings for the tank plant models.
// Defaults here are the nominal plant; instantiations may override them.
// level_region() maps a level onto the coarse region reported to the bench.
package tank_pkg;

  localparam int DEF_LEVEL_W   = 8;
  localparam int DEF_LEVEL_MAX = 255;
  localparam int DEF_LOW_TH    = 64;
  localparam int DEF_HIGH_TH   = 192;
  localparam int DEF_PUMP_RATE = 2;
  localparam int DEF_TICK_DIV  = 4;

  typedef enum logic [1:0] {
    REGION_DRY     = 2'd0,
    REGION_PARTIAL = 2'd1,
    REGION_FULL    = 2'd2,
    REGION_BRIM    = 2'd3
  } region_e;

  // Brim is checked first so a full-scale level never reports FULL.
  function automatic region_e level_region(input int unsigned lvl,
                                           input int unsigned low_th,
                                           input int unsigned high_th,
                                           input int unsigned level_max);
    region_e r;
    if (lvl >= level_max)    r = REGION_BRIM;
    else if (lvl >= high_th) r = REGION_FULL;
    else if (lvl >= low_th)  r = REGION_PARTIAL;
    else                     r = REGION_DRY;
    return r;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: divides Clk into a one-cycle tick every TICK_DIV enabled cycles.
// tick is combinational from the count and enable; the count wraps on the tick cycle.
// The count holds while enable is low; tick is forced low during reset.
module tick_prescaler
  import tank_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV
) (
  input  logic Clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Tick on the last count of the period, and advance/wrap the count while enabled.
  always_comb begin
    tick  = enable && (cnt_q == LAST) && !reset;
    cnt_d = cnt_q;
    if (enable) begin
      if (cnt_q == LAST) cnt_d = '0;
      else               cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/tank_model.sv
// tank_model: tank plant integrating pump inflow minus demand on each prescaled tick.
// Level and sensors update one Clk after a tick/load cycle; S, I, region match level.
// Optional TANK_STATS_EN adds starts1/starts2 pump start counters.
module tank_model
  import tank_pkg::*;
#(
  parameter int LEVEL_W   = DEF_LEVEL_W,
  parameter int LEVEL_MAX = DEF_LEVEL_MAX,
  parameter int LOW_TH    = DEF_LOW_TH,
  parameter int HIGH_TH   = DEF_HIGH_TH,
  parameter int PUMP_RATE = DEF_PUMP_RATE,
  parameter int TICK_DIV  = DEF_TICK_DIV
) (
  input  logic               Clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               b1,
  input  logic               b2,
  input  logic [3:0]         demand,
  input  logic               load,
  input  logic [LEVEL_W-1:0] load_value,
  input  logic               clear_alarm,
  output logic               S,
  output logic               I,
  output logic [LEVEL_W-1:0] level,
  output logic [1:0]         region,
  output logic               tick,
  output logic               overflow,
  output logic               starved
`ifdef TANK_STATS_EN
  ,
  output logic [7:0]         starts1,
  output logic [7:0]         starts2
`endif
);

  // Four guard bits cover the worst-case inflow above LEVEL_MAX and the sign of a drain below 0.
  localparam int RAW_W = LEVEL_W + 4;
  localparam logic [LEVEL_W-1:0] LMAX    = LEVEL_W'(LEVEL_MAX);
  localparam logic [LEVEL_W-1:0] LOW_LV  = LEVEL_W'(LOW_TH);
  localparam logic [LEVEL_W-1:0] HIGH_LV = LEVEL_W'(HIGH_TH);
  localparam logic [RAW_W-1:0]   RMAX    = RAW_W'(LEVEL_MAX);

  logic [LEVEL_W-1:0] level_q, level_d;
  logic               s_q, s_d, i_q, i_d;
  region_e            region_q, region_d;
  logic               overflow_q, overflow_d;
  logic               starved_q, starved_d;

  logic [1:0]       pumps;
  logic [RAW_W-1:0] raw;
  logic             raw_neg, raw_over, ov_evt, st_evt;

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .Clk    (Clk),
    .reset  (reset),
    .enable (enable),
    .tick   (tick)
  );

  // Next level: load beats integration; integration clamps to [0, LEVEL_MAX] and flags the clip.
  always_comb begin
    pumps    = {1'b0, b1} + {1'b0, b2};
    raw      = RAW_W'(level_q) + RAW_W'(PUMP_RATE) * RAW_W'(pumps) - RAW_W'(demand);
    raw_neg  = raw[RAW_W-1];
    raw_over = !raw_neg && (raw > RMAX);
    level_d  = level_q;
    ov_evt   = 1'b0;
    st_evt   = 1'b0;
    if (load) begin
      level_d = (load_value > LMAX) ? LMAX : load_value;
    end else if (tick) begin
      if (raw_neg) begin
        level_d = '0;
        st_evt  = 1'b1;
      end else if (raw_over) begin
        level_d = LMAX;
        ov_evt  = 1'b1;
      end else begin
        level_d = raw[LEVEL_W-1:0];
      end
    end
    // A new event in the clearing cycle keeps the alarm set.
    overflow_d = (overflow_q && !clear_alarm) || ov_evt;
    starved_d  = (starved_q && !clear_alarm) || st_evt;
    s_d        = (level_d >= HIGH_LV);
    i_d        = (level_d >= LOW_LV);
    region_d   = level_region(32'(level_d), 32'(LOW_TH), 32'(HIGH_TH), 32'(LEVEL_MAX));
  end

  // Plant state; sensors and region are registered from level_d so they never lag level.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      level_q    <= '0;
      s_q        <= 1'b0;
      i_q        <= 1'b0;
      region_q   <= REGION_DRY;
      overflow_q <= 1'b0;
      starved_q  <= 1'b0;
    end else begin
      level_q    <= level_d;
      s_q        <= s_d;
      i_q        <= i_d;
      region_q   <= region_d;
      overflow_q <= overflow_d;
      starved_q  <= starved_d;
    end
  end

  assign level    = level_q;
  assign S        = s_q;
  assign I        = i_q;
  assign region   = region_q;
  assign overflow = overflow_q;
  assign starved  = starved_q;

`ifdef TANK_STATS_EN
  logic       b1_prev_q, b2_prev_q;
  logic [7:0] starts1_q, starts1_d, starts2_q, starts2_d;

  // Saturating rising-edge counters on the raw pump commands, independent of enable.
  always_comb begin
    starts1_d = starts1_q;
    starts2_d = starts2_q;
    if (b1 && !b1_prev_q && (starts1_q != 8'hFF)) starts1_d = starts1_q + 8'd1;
    if (b2 && !b2_prev_q && (starts2_q != 8'hFF)) starts2_d = starts2_q + 8'd1;
  end

  // Edge history and counter registers.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      b1_prev_q <= 1'b0;
      b2_prev_q <= 1'b0;
      starts1_q <= '0;
      starts2_q <= '0;
    end else begin
      b1_prev_q <= b1;
      b2_prev_q <= b2;
      starts1_q <= starts1_d;
      starts2_q <= starts2_d;
    end
  end

  assign starts1 = starts1_q;
  assign starts2 = starts2_q;
`endif

endmodule

// File: tb/tb_tank_model.sv
// tb_tank_model: randomized and directed stimulus for tank_model with a scoreboard.
// Each stimulus cycle pushes the expected outputs; a negedge monitor pops and compares.
// The reference model uses plain integer arithmetic over the plant rules.
module tb_tank_model;

  localparam int TD   = 4;
  localparam int LMAX = 255;
  localparam int LOWT = 64;
  localparam int HIGT = 192;
  localparam int RATE = 2;

  logic       Clk = 1'b0;
  logic       reset, enable, b1, b2, load, clear_alarm;
  logic [3:0] demand;
  logic [7:0] load_value;
  logic       S, I, tick, overflow, starved;
  logic [7:0] level;
  logic [1:0] region;
`ifdef TANK_STATS_EN
  logic [7:0] starts1, starts2;
`endif

  always #5 Clk = ~Clk;

  tank_model dut (
    .Clk         (Clk),
    .reset       (reset),
    .enable      (enable),
    .b1          (b1),
    .b2          (b2),
    .demand      (demand),
    .load        (load),
    .load_value  (load_value),
    .clear_alarm (clear_alarm),
    .S           (S),
    .I           (I),
    .level       (level),
    .region      (region),
    .tick        (tick),
    .overflow    (overflow),
    .starved     (starved)
`ifdef TANK_STATS_EN
    ,
    .starts1     (starts1),
    .starts2     (starts2)
`endif
  );

  typedef struct {
    bit tk;
    int lvl;
    bit s;
    bit i;
    int rg;
    bit ov;
    bit st;
    int c1;
    int c2;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  // reference model state
  int m_level, m_pcnt, m_c1, m_c2;
  bit m_ov, m_st, m_prev1, m_prev2, m_tick;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  function automatic int region_of(input int lvl);
    if (lvl == LMAX)      return 3;
    else if (lvl >= HIGT) return 2;
    else if (lvl >= LOWT) return 1;
    return 0;
  endfunction

  task automatic model_zero();
    m_level = 0; m_pcnt = 0; m_c1 = 0; m_c2 = 0;
    m_ov = 0; m_st = 0; m_prev1 = 0; m_prev2 = 0;
  endtask

  // Apply one clock edge to the model using the inputs held during the cycle that just ended.
  task automatic model_edge();
    bit tk, ov_e, st_e;
    int raw;
    if (reset) begin
      model_zero();
    end else begin
      tk   = enable && (m_pcnt == TD - 1);
      ov_e = 0;
      st_e = 0;
      if (enable) m_pcnt = (m_pcnt + 1) % TD;
      if (load) begin
        m_level = (int'(load_value) > LMAX) ? LMAX : int'(load_value);
      end else if (tk) begin
        raw = m_level + RATE * (int'(b1) + int'(b2)) - int'(demand);
        if (raw < 0) begin
          m_level = 0; st_e = 1;
        end else if (raw > LMAX) begin
          m_level = LMAX; ov_e = 1;
        end else begin
          m_level = raw;
        end
      end
      m_ov = (m_ov && !clear_alarm) || ov_e;
      m_st = (m_st && !clear_alarm) || st_e;
      if (b1 && !m_prev1 && m_c1 < 255) m_c1++;
      if (b2 && !m_prev2 && m_c2 < 255) m_c2++;
      m_prev1 = b1;
      m_prev2 = b2;
    end
  endtask

  // One stimulus cycle: advance model past the edge, drive new inputs, push expectation.
  task automatic cyc(input bit r, input bit en, input bit p1, input bit p2, input int dem,
                     input bit ld, input int lv, input bit clr);
    exp_t e;
    @(posedge Clk);
    #1;
    model_edge();
    reset = r; enable = en; b1 = p1; b2 = p2; demand = 4'(dem);
    load = ld; load_value = 8'(lv); clear_alarm = clr;
    if (r) model_zero();
    m_tick = !r && en && (m_pcnt == TD - 1);
    e.tk  = m_tick;
    e.lvl = m_level;
    e.s   = (m_level >= HIGT);
    e.i   = (m_level >= LOWT);
    e.rg  = region_of(m_level);
    e.ov  = m_ov;
    e.st  = m_st;
    e.c1  = m_c1;
    e.c2  = m_c2;
    sbq.push_back(e);
  endtask

  // Keep cycling until the model has issued a tick, so the following cycle shows the result.
  task automatic run_to_tick(input bit p1, input bit p2, input int dem, input bit clr);
    int n;
    n = 0;
    do begin
      cyc(0, 1, p1, p2, dem, 0, 0, clr);
      n++;
    end while (!m_tick && n < 4 * TD);
    if (!m_tick) chk("tick_bound", 32'(n), 32'(0));
  endtask

  // Monitor: compare every presented output against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge Clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("sb_tick",     32'(tick),     32'(e.tk));
        chk("sb_level",    32'(level),    32'(e.lvl));
        chk("sb_S",        32'(S),        32'(e.s));
        chk("sb_I",        32'(I),        32'(e.i));
        chk("sb_region",   32'(region),   32'(e.rg));
        chk("sb_overflow", 32'(overflow), 32'(e.ov));
        chk("sb_starved",  32'(starved),  32'(e.st));
`ifdef TANK_STATS_EN
        chk("sb_starts1",  32'(starts1),  32'(e.c1));
        chk("sb_starts2",  32'(starts2),  32'(e.c2));
`endif
      end
    end
  end

  initial begin
    bit fill;
    reset = 1; enable = 0; b1 = 0; b2 = 0; demand = '0;
    load = 0; load_value = '0; clear_alarm = 0;
    model_zero();
    m_tick = 0;

    repeat (3) cyc(1, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_level", 32'(level), 32'(0));
    chk("rst_region", 32'(region), 32'(0));

    // idle: level stays 0, tick every 4th cycle
    repeat (12) cyc(0, 1, 0, 0, 0, 0, 0, 0);

    // fill at +4 per tick
    repeat (64) cyc(0, 1, 1, 1, 0, 0, 0, 0);
    cyc(0, 1, 1, 1, 0, 0, 0, 0);
    chk("fill16_level", 32'(level), 32'(64));
    chk("fill16_I", 32'(I), 32'(1));
    chk("fill16_S", 32'(S), 32'(0));
    repeat (127) cyc(0, 1, 1, 1, 0, 0, 0, 0);
    cyc(0, 1, 1, 1, 0, 0, 0, 0);
    chk("fill48_level", 32'(level), 32'(192));
    chk("fill48_S", 32'(S), 32'(1));
    chk("fill48_region", 32'(region), 32'(2));

    // clip at the ceiling
    cyc(0, 1, 1, 1, 0, 1, 254, 0);
    run_to_tick(1, 1, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0, 0);
    chk("brim_level", 32'(level), 32'(255));
    chk("brim_region", 32'(region), 32'(3));
    chk("brim_overflow", 32'(overflow), 32'(1));
    cyc(0, 1, 0, 0, 0, 0, 0, 1);
    cyc(0, 1, 0, 0, 0, 0, 0, 0);
    chk("clear_overflow", 32'(overflow), 32'(0));
    run_to_tick(1, 1, 0, 1);
    cyc(0, 1, 0, 0, 0, 0, 0, 0);
    chk("clear_vs_clip", 32'(overflow), 32'(1));

    // drain below zero
    cyc(0, 1, 0, 0, 5, 1, 3, 0);
    run_to_tick(0, 0, 5, 0);
    cyc(0, 1, 0, 0, 0, 0, 0, 0);
    chk("starve_level", 32'(level), 32'(0));
    chk("starve_flag", 32'(starved), 32'(1));
    chk("starve_I", 32'(I), 32'(0));

    // balanced inflow/outflow, then frozen prescaler
    cyc(0, 1, 1, 0, 2, 1, 100, 1);
    repeat (40) cyc(0, 1, 1, 0, 2, 0, 0, 0);
    chk("hold_level", 32'(level), 32'(100));
    repeat (10) cyc(0, 0, 1, 1, 0, 0, 0, 0);
    chk("frozen_level", 32'(level), 32'(100));

    // async reset mid-fill with an alarm pending
    cyc(0, 1, 0, 0, 5, 1, 3, 0);
    run_to_tick(0, 0, 5, 0);
    cyc(0, 1, 1, 1, 0, 1, 126, 0);
    run_to_tick(1, 1, 0, 0);
    cyc(0, 1, 1, 1, 0, 0, 0, 0);
    chk("midfill_level", 32'(level), 32'(130));
    chk("midfill_starved", 32'(starved), 32'(1));
    cyc(1, 1, 1, 1, 0, 0, 0, 0);
    #1;
    chk("async_level", 32'(level), 32'(0));
    chk("async_S", 32'(S), 32'(0));
    chk("async_I", 32'(I), 32'(0));
    chk("async_starved", 32'(starved), 32'(0));
    repeat (2) cyc(1, 1, 0, 0, 0, 0, 0, 0);

    // three b1 pulses
    cyc(0, 1, 0, 0, 0, 0, 0, 0);
    repeat (3) begin
      cyc(0, 1, 1, 0, 0, 0, 0, 0);
      cyc(0, 1, 0, 0, 0, 0, 0, 0);
    end
    cyc(0, 1, 0, 0, 0, 0, 0, 0);
`ifdef TANK_STATS_EN
    chk("starts1_three", 32'(starts1), 32'(3));
`endif

    // randomized phase alternating fill-biased and drain-biased windows
    fill = 1;
    for (int k = 0; k < 800; k++) begin
      if (k % 60 == 0) fill = ~fill;
      cyc(($urandom % 250) == 0,
          ($urandom % 8) != 0,
          fill ? (($urandom % 4) != 0) : (($urandom % 4) == 0),
          fill ? (($urandom % 4) != 0) : (($urandom % 4) == 0),
          fill ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 15)),
          ($urandom % 30) == 0,
          int'($urandom_range(0, 255)),
          ($urandom % 12) == 0);
    end

    @(negedge Clk);
    #1;
    chk("sb_drain", 32'(sbq.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tank_model.md
Name: tank_model

Overview:
- Behavioural plant model for the two-pump tank controller, i.e. the other end of the sensor/pump interface.
- Consumes the pump commands b1/b2 and a draw-off demand. Integrates a tank level on a prescaled tick.
- Produces the level sensors S (superior) and I (inferior) that the Moore pump controller samples.
- Used in closed-loop benches and as a synthesizable stimulus source on the board.

Parameters:
- LEVEL_W, 8: level register width.
- LEVEL_MAX, 255: saturation ceiling, must be <= 2^LEVEL_W-1.
- LOW_TH, 64: I asserts when level >= LOW_TH.
- HIGH_TH, 192: S asserts when level >= HIGH_TH; must satisfy LOW_TH < HIGH_TH <= LEVEL_MAX.
- PUMP_RATE, 2: units added per tick per active pump.
- TICK_DIV, 4: Clk cycles per integration tick, >= 1.

Ports:
- Clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- enable  in  1  prescaler runs only when 1.
- b1  in  1  pump 1 command.
- b2  in  1  pump 2 command.
- demand  in  4  units drained per tick.
- load  in  1  synchronous level preload strobe.
- load_value  in  LEVEL_W  preload value.
- clear_alarm  in  1  clears sticky alarms.
- S  out  1  high sensor wet.
- I  out  1  low sensor wet.
- level  out  LEVEL_W  current level.
- region  out  2  0 DRY, 1 PARTIAL, 2 FULL, 3 BRIM.
- tick  out  1  one-cycle pulse on integration cycles.
- overflow  out  1  sticky: inflow clipped at LEVEL_MAX.
- starved  out  1  sticky: demand unmet at 0.

Behaviour:
- Reset: async, active-high. While asserted: level=0, S=0, I=0, region=DRY, tick=0, overflow=0, starved=0, prescaler=0. Release takes effect at the next Clk edge. Reset asserted mid-fill clears immediately.
- Prescaler:
  - Counts 0..TICK_DIV-1 while enable=1 and holds its value when enable=0.
  - tick=1 combinationally when count==TICK_DIV-1 and enable=1; the count then wraps to 0.
  - TICK_DIV=1 gives tick=1 on every enabled cycle.
- Integration, on the tick cycle:
  - raw = level + PUMP_RATE*(b1+b2) - demand, computed signed in LEVEL_W+4 bits.
  - level <= clamp(raw, 0, LEVEL_MAX).
  - raw>LEVEL_MAX sets overflow; raw<0 sets starved.
- Load: load=1 has priority over tick. level <= min(load_value, LEVEL_MAX). No alarm is set. The prescaler still advances; the pending tick is consumed without integrating.
- Alarms: clear_alarm clears both alarms. If an alarm event occurs in the same cycle as clear_alarm, the event wins and the alarm stays 1.
- Sensors and region:
  - S, I and region are registered from the next-level value, so they are always consistent with the level output in the same cycle. No extra latency.
  - S = level>=HIGH_TH; I = level>=LOW_TH. S=1 with I=0 is unreachable.
  - Region states by level:
    - DRY: level<LOW_TH.
    - PARTIAL: LOW_TH<=level<HIGH_TH.
    - FULL: HIGH_TH<=level<LEVEL_MAX.
    - BRIM: level==LEVEL_MAX.
  - Transitions follow level; a single tick may skip regions, e.g. after a load.
- b1/b2/demand are sampled only on tick or load cycles.

Optional Feature:
- Macro: TANK_STATS_EN.
- When defined, adds outputs starts1 and starts2, 8 bits each.
  - They count rising edges of b1 and b2, sampled every Clk regardless of enable.
  - Counters saturate at 255 and reset to 0.
  - clear_alarm does not affect them.
- When undefined, these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- tank_pkg holds:
  - region encodings: REGION_DRY=0, REGION_PARTIAL=1, REGION_FULL=2, REGION_BRIM=3.
  - default thresholds and rate constants.
- One natural sub-module: tick_prescaler (parameter TICK_DIV; ports Clk, reset, enable, tick). It is reused by other plant models.

Test Plan:
- Reset, enable=1, b1=b2=0, demand=0 -> level stays 0, S=I=0, region=0; tick pulses every 4th Clk.
- From 0, b1=b2=1, demand=0 -> +4 per tick. After the 16th tick level=64 and I=1. After the 48th tick level=192, S=1, region=2.
- load_value=254, then b1=b2=1 -> after the next tick level=255, region=3, overflow=1. clear_alarm pulse -> overflow=0. Clear coincident with a further clip -> overflow stays 1.
- load_value=3, pumps off, demand=5 -> after the next tick level=0, starved=1, I=0.
- level=100, b1=1, b2=0, demand=2 -> level holds 100 across 10 ticks. enable=0 -> no tick and level frozen.
- Reset asserted asynchronously mid-fill at level 130 -> level=0, S=I=0 and alarms cleared without waiting for a Clk edge. With TANK_STATS_EN, 3 b1 pulses -> starts1=3.
